// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receive path.
//  - FSM state encoding for the decoder
//  - NEC timing windows, expressed in 10 us timing ticks (inclusive bounds)
//  - PHASE_W: width of the saturating phase-length counter
//  - in_window(): inclusive range test of a measured phase length
package ir_pkg;

    localparam int PHASE_W = 11;
    localparam logic [PHASE_W-1:0] PHASE_MAX = 11'd2047;

    localparam int NEC_LEAD_LO_MIN  = 800;
    localparam int NEC_LEAD_LO_MAX  = 1000;
    localparam int NEC_LEAD_HI_MIN  = 400;
    localparam int NEC_LEAD_HI_MAX  = 500;
    localparam int NEC_RPT_HI_MIN   = 180;
    localparam int NEC_RPT_HI_MAX   = 270;
    localparam int NEC_BIT_LO_MIN   = 40;
    localparam int NEC_BIT_LO_MAX   = 72;
    localparam int NEC_BIT0_HI_MIN  = 40;
    localparam int NEC_BIT0_HI_MAX  = 72;
    localparam int NEC_BIT1_HI_MIN  = 140;
    localparam int NEC_BIT1_HI_MAX  = 200;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEAD_LO = 3'd1,
        ST_LEAD_HI = 3'd2,
        ST_BIT_LO  = 3'd3,
        ST_BIT_HI  = 3'd4,
        ST_CHECK   = 3'd5,
        ST_RPT_LO  = 3'd6
    } ir_state_e;

    function automatic logic in_window(input logic [PHASE_W-1:0] t, input int lo, input int hi);
        return (int'(t) >= lo) && (int'(t) <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Front end of the IR receiver: synchronises the raw pin, detects edges on the
// synchronised level and measures how long the current level has lasted.
// Ports:
//  clk          in   clock
//  reset        in   synchronous, active-high
//  ir_rx        in   raw asynchronous receiver output (low = carrier)
//  fall         out  one-cycle strobe, synced level went 1 -> 0
//  rise         out  one-cycle strobe, synced level went 0 -> 1
//  phase_ticks  out  ticks elapsed since the last edge (saturating)
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter int TICK_DIV = 250
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ir_rx,
    output logic               fall,
    output logic               rise,
    output logic [PHASE_W-1:0] phase_ticks
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Two synchroniser flops, then one more for edge detection. They reset
    // to the idle-high level so leaving reset never fakes a falling edge.
    logic [1:0]         sync_q;
    logic               rx_prev_q;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tick;
    logic               rx_s;

    assign rx_s = sync_q[1];
    assign fall = rx_prev_q & ~rx_s;
    assign rise = ~rx_prev_q & rx_s;
    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        phase_d = phase_q;
        if (fall || rise) begin
            phase_d = '0;
        end else if (tick && (phase_q != PHASE_MAX)) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            presc_q   <= '0;
            phase_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], ir_rx};
            rx_prev_q <= rx_s;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
        end
    end

    assign phase_ticks = phase_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder. Walks leader / 32 data bits / stop burst,
// validates every phase against its timing window and publishes the address
// and command bytes of each good frame. Repeat codes are reported only after
// a good frame has been seen since reset.
// Ports:
//  clk        in   clock
//  reset      in   synchronous, active-high
//  ir_rx      in   raw IR receiver output, idle high
//  frame_vld  out  one-cycle strobe, addr/cmd updated in the same cycle
//  rpt_vld    out  one-cycle strobe, repeat code seen
//  err        out  one-cycle strobe, bad timing / inverse mismatch / timeout
//  addr, cmd  out  last good address / command byte (held)
//  busy       out  high while a frame is being received
module ir_nec_decoder
    import ir_pkg::*;
#(
    parameter int TICK_DIV  = 250,
    parameter bit CHECK_INV = 1'b1,
    parameter int TIMEOUT   = 1100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_rx,
    output logic       frame_vld,
    output logic       rpt_vld,
    output logic       err,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       busy
);

    logic               fall, rise;
    logic [PHASE_W-1:0] phase_ticks;

    ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .ir_rx       (ir_rx),
        .fall        (fall),
        .rise        (rise),
        .phase_ticks (phase_ticks)
    );

    ir_state_e   state_q;
    logic [5:0]  bitcnt_q;
    logic [31:0] sr_q;
    logic [7:0]  addr_q, cmd_q;
    logic        frame_vld_q, rpt_vld_q, err_q, have_frame_q;
    logic        inv_bad, timed_out;

    assign inv_bad   = (sr_q[15:8] != ~sr_q[7:0]) || (sr_q[31:24] != ~sr_q[23:16]);
    assign timed_out = int'(phase_ticks) > TIMEOUT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            frame_vld_q  <= 1'b0;
            rpt_vld_q    <= 1'b0;
            err_q        <= 1'b0;
            have_frame_q <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            rpt_vld_q   <= 1'b0;
            err_q       <= 1'b0;
            // A phase that never ends (stuck low, or line gone quiet mid-frame)
            // must not leave the decoder parked outside IDLE.
            if ((state_q != ST_IDLE) && timed_out) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fall) state_q <= ST_LEAD_LO;
                    end
                    ST_LEAD_LO: begin
                        if (rise) begin
                            if (in_window(phase_ticks, NEC_LEAD_LO_MIN, NEC_LEAD_LO_MAX)) begin
                                state_q <= ST_LEAD_HI;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_LEAD_HI: begin
                        if (fall) begin
                            if (in_window(phase_ticks, NEC_LEAD_HI_MIN, NEC_LEAD_HI_MAX)) begin
                                bitcnt_q <= '0;
                                state_q  <= ST_BIT_LO;
                            end else if (in_window(phase_ticks, NEC_RPT_HI_MIN, NEC_RPT_HI_MAX)) begin
                                state_q <= ST_RPT_LO;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_BIT_LO: begin
                        // The 33rd burst is the stop burst that closes the frame.
                        if (rise) begin
                            if (in_window(phase_ticks, NEC_BIT_LO_MIN, NEC_BIT_LO_MAX)) begin
                                state_q <= (bitcnt_q == 6'd32) ? ST_CHECK : ST_BIT_HI;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_BIT_HI: begin
                        // LSB first: new bits enter at the top and move down.
                        if (fall) begin
                            if (in_window(phase_ticks, NEC_BIT0_HI_MIN, NEC_BIT0_HI_MAX)) begin
                                sr_q     <= {1'b0, sr_q[31:1]};
                                bitcnt_q <= bitcnt_q + 1'b1;
                                state_q  <= ST_BIT_LO;
                            end else if (in_window(phase_ticks, NEC_BIT1_HI_MIN, NEC_BIT1_HI_MAX)) begin
                                sr_q     <= {1'b1, sr_q[31:1]};
                                bitcnt_q <= bitcnt_q + 1'b1;
                                state_q  <= ST_BIT_LO;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (CHECK_INV && inv_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q       <= sr_q[7:0];
                            cmd_q        <= sr_q[23:16];
                            frame_vld_q  <= 1'b1;
                            have_frame_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    ST_RPT_LO: begin
                        if (rise) begin
                            if (in_window(phase_ticks, NEC_BIT_LO_MIN, NEC_BIT_LO_MAX) && have_frame_q) begin
                                rpt_vld_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign frame_vld = frame_vld_q;
    assign rpt_vld   = rpt_vld_q;
    assign err       = err_q;
    assign addr      = addr_q;
    assign cmd       = cmd_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Scoreboard bench: two decoders share one IR line, one with the inverse-byte
// check enabled (dut 0) and one without (dut 1). A transaction-level model
// queues the expected event per decoder; a monitor pops on every strobe.
// Timing: the tick divider is reduced so each 10 us tick is one clock, which
// keeps whole NEC frames short in simulation while leaving windows unchanged.
module tb_ir_nec_decoder;

    localparam int TICK_DIV = 1;

    typedef enum int {EV_FRAME, EV_RPT, EV_ERR} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] addr;
        logic [7:0] cmd;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic ir_rx;
    logic fv_a, rv_a, er_a, busy_a, fv_b, rv_b, er_b, busy_b;
    logic [7:0] addr_a, cmd_a, addr_b, cmd_b;

    int n_tests = 0;
    int n_fail  = 0;

    ev_t exp_a[$];
    ev_t exp_b[$];

    // Reference state per decoder: last good bytes and whether one was seen.
    logic [7:0] m_addr [2];
    logic [7:0] m_cmd  [2];
    bit         m_have [2];

    always #20 clk = ~clk;

    ir_nec_decoder #(.TICK_DIV(TICK_DIV), .CHECK_INV(1'b1), .TIMEOUT(1100)) dut_a (
        .clk(clk), .reset(reset), .ir_rx(ir_rx), .frame_vld(fv_a), .rpt_vld(rv_a),
        .err(er_a), .addr(addr_a), .cmd(cmd_a), .busy(busy_a)
    );

    ir_nec_decoder #(.TICK_DIV(TICK_DIV), .CHECK_INV(1'b0), .TIMEOUT(1100)) dut_b (
        .clk(clk), .reset(reset), .ir_rx(ir_rx), .frame_vld(fv_b), .rpt_vld(rv_b),
        .err(er_b), .addr(addr_b), .cmd(cmd_b), .busy(busy_b)
    );

    // ---------------- reference model ----------------
    task automatic push_ev(input int d, input ev_e k);
        ev_t e;
        e.kind = k;
        e.addr = m_addr[d];
        e.cmd  = m_cmd[d];
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = 8'h00;
            m_cmd[d]  = 8'h00;
            m_have[d] = 1'b0;
        end
    endtask

    // w holds the four bytes in transmission order, first byte in w[7:0].
    task automatic model_frame(input logic [31:0] w);
        logic [7:0] a, na, c, nc;
        bit pair_ok;
        a  = w[7:0];
        na = w[15:8];
        c  = w[23:16];
        nc = w[31:24];
        pair_ok = (na == 8'(255 - a)) && (nc == 8'(255 - c));
        for (int d = 0; d < 2; d++) begin
            if ((d == 0) && !pair_ok) begin
                push_ev(d, EV_ERR);
            end else begin
                m_addr[d] = a;
                m_cmd[d]  = c;
                m_have[d] = 1'b1;
                push_ev(d, EV_FRAME);
            end
        end
    endtask

    task automatic model_repeat();
        for (int d = 0; d < 2; d++) push_ev(d, m_have[d] ? EV_RPT : EV_ERR);
    endtask

    task automatic model_err();
        for (int d = 0; d < 2; d++) push_ev(d, EV_ERR);
    endtask

    // ---------------- waveform driver (durations in us) ----------------
    function automatic int rnd10(input int lo, input int hi);
        return 10 * int'($urandom_range(hi, lo));
    endfunction

    task automatic drive(input logic lvl, input int us);
        ir_rx = lvl;
        repeat (us * TICK_DIV / 10) @(negedge clk);
    endtask

    task automatic send_leader();
        drive(1'b0, rnd10(830, 970));
        drive(1'b1, rnd10(420, 480));
    endtask

    task automatic send_bit(input logic b);
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, b ? rnd10(150, 190) : rnd10(45, 65));
    endtask

    task automatic send_frame(input logic [31:0] w);
        model_frame(w);
        $display("[TB] send frame bytes=%02h %02h %02h %02h", w[7:0], w[15:8], w[23:16], w[31:24]);
        send_leader();
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, 300);
    endtask

    task automatic send_repeat();
        model_repeat();
        $display("[TB] send repeat");
        drive(1'b0, rnd10(830, 970));
        drive(1'b1, rnd10(200, 250));
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, 300);
    endtask

    function automatic logic [31:0] good_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end else begin
            $display("[TB] check %s = %0h ok", name, act);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_dut(input int d, input logic fv, input logic rv, input logic er,
                             input logic [7:0] a, input logic [7:0] c);
        ev_t got, e;
        bit have_e;
        if (!(fv || rv || er)) return;
        got.kind = fv ? EV_FRAME : (rv ? EV_RPT : EV_ERR);
        got.addr = a;
        got.cmd  = c;
        $display("[TB] dut%0d event=%s addr=%02h cmd=%02h", d, got.kind.name(), a, c);
        n_tests++;
        if ((int'(fv) + int'(rv) + int'(er)) > 1) begin
            n_fail++;
            $display("FAIL strobe_onehot dut%0d got fv=%0b rv=%0b err=%0b required one", d, fv, rv, er);
            return;
        end
        have_e = 1'b0;
        if (d == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have_e = 1'b1; end
        if (d == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have_e = 1'b1; end
        if (!have_e) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d got=%s required=none", d, got.kind.name());
        end else if (got.kind != e.kind || got.addr != e.addr || got.cmd != e.cmd) begin
            n_fail++;
            $display("FAIL event dut%0d got=%s/%02h/%02h required=%s/%02h/%02h", d,
                     got.kind.name(), got.addr, got.cmd, e.kind.name(), e.addr, e.cmd);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check_dut(0, fv_a, rv_a, er_a, addr_a, cmd_a);
            check_dut(1, fv_b, rv_b, er_b, addr_b, cmd_b);
        end
    end

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        reset = 1'b1;
        ir_rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check("reset_state_a", {12'h0, fv_a, rv_a, er_a, busy_a, addr_a, cmd_a}, 32'h0);
        check("reset_state_b", {12'h0, fv_b, rv_b, er_b, busy_b, addr_b, cmd_b}, 32'h0);
        drive(1'b1, 200);

        // Repeat with no frame since reset
        send_repeat();

        // Reference frame addr 0x00 cmd 0x45, then its repeat
        send_frame(good_word(8'h00, 8'h45));
        send_repeat();
        check("held_after_repeat", {16'h0, addr_a, cmd_a}, 32'h0045);

        // ~cmd corrupted: 0xBB instead of 0xBA
        send_frame({8'hBB, 8'h45, 8'hFF, 8'h00});
        check("held_after_badinv", {16'h0, addr_a, cmd_a}, 32'h0045);

        // Leader low far too short, then a good frame right behind it
        model_err();
        $display("[TB] send short leader");
        drive(1'b0, 7000);
        drive(1'b1, 300);
        send_frame(good_word(8'($urandom), 8'($urandom)));

        // Stuck low mid-bit: timeout
        model_err();
        $display("[TB] send stuck-low");
        w = $urandom;
        send_leader();
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        drive(1'b0, 20000);
        check("busy_after_stuck_a", {31'h0, busy_a}, 32'h0);
        check("busy_after_stuck_b", {31'h0, busy_b}, 32'h0);
        drive(1'b1, 300);

        // Bit high between the '0' and '1' windows
        model_err();
        $display("[TB] send bad bit-high");
        send_leader();
        for (int i = 0; i < 3; i++) send_bit(w[i]);
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, 1000);
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, 300);

        // Reset during bit 17 (index 16), while the line is high
        $display("[TB] reset mid-frame");
        send_leader();
        for (int i = 0; i < 16; i++) send_bit(w[i]);
        drive(1'b0, rnd10(45, 65));
        drive(1'b1, 300);
        check("busy_midframe", {31'h0, busy_a}, 32'h1);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_a", {12'h0, fv_a, rv_a, er_a, busy_a, addr_a, cmd_a}, 32'h0);
        check("reset_mid_b", {12'h0, fv_b, rv_b, er_b, busy_b, addr_b, cmd_b}, 32'h0);
        drive(1'b1, 300);
        send_frame(good_word(8'($urandom), 8'($urandom)));

        // One-tick glitch while idle
        model_err();
        $display("[TB] send glitch");
        ir_rx = 1'b0;
        @(negedge clk);
        drive(1'b1, 300);

        // Fully random 32-bit payload: the model decides per decoder
        send_frame($urandom);

        repeat (50) @(negedge clk);
        check("pending_dut0", exp_a.size(), 32'h0);
        check("pending_dut1", exp_b.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
